// File: rtl/fpu_lzc_pkg.sv
// Shared helpers for the pipelined leading/trailing-zero counter:
// tree depth, count width and level-to-register-stage mapping.
package fpu_lzc_pkg;

    function automatic int lzc_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lzc_cnt_w(input int width);
        return lzc_log2(width) + 1;
    endfunction

    function automatic int lzc_stages(input int levels, input int every);
        return (levels + every - 1) / every;
    endfunction

    function automatic int lzc_stage_of(input int level, input int every);
        return (level - 1) / every;
    endfunction

    // A register follows every `every` levels, and always after the root.
    function automatic bit lzc_is_boundary(input int level, input int levels, input int every);
        return ((level % every) == 0) || (level == levels);
    endfunction

endpackage

// File: rtl/fpu_lzc_merge.sv
// One priority-tree merge node: the high half wins when it holds a one,
// otherwise the count is the full high span plus the low count.
module fpu_lzc_merge #(
    parameter int N = 1
) (
    input  logic         vh_i,
    input  logic [N-1:0] ch_i,
    input  logic         vl_i,
    input  logic [N-1:0] cl_i,
    output logic         v_o,
    output logic [N:0]   c_o
);

    assign v_o = vh_i | vl_i;
    assign c_o = vh_i ? {1'b0, ch_i} : {1'b1, cl_i};

endmodule

// File: rtl/fpu_lzc_pipe.sv
// Pipelined LZ/TZ counter for FPU normalisation: log2(WIDTH)-level priority
// tree with a register stage every PIPE_EVERY levels and a global stall.
module fpu_lzc_pipe
    import fpu_lzc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_trail,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [lzc_cnt_w(WIDTH)-1:0]  out_count,
    output logic                         out_zero,
    output logic [TAG_W-1:0]             out_tag
);

    localparam int L  = lzc_log2(WIDTH);
    localparam int CW = lzc_cnt_w(WIDTH);
    localparam int S  = lzc_stages(L, PIPE_EVERY);
    localparam int TW = S * TAG_W;

    logic                    adv;
    logic [S-1:0]            vld_q;
    logic [S-1:0][TAG_W-1:0] tag_q;
    logic [WIDTH-1:0]        data_ord;

    assign out_valid = vld_q[S-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    // Valid/tag shift chain; stage 0 takes the input beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else if (adv) begin
            vld_q <= S'({vld_q, in_valid});
            tag_q <= TW'({tag_q, in_tag});
        end
    end

    // Trailing-zero mode is leading-zero counting on the bit-reversed operand.
    always_comb begin
        data_ord = in_data;
        for (int i = 0; i < WIDTH; i++) begin
            data_ord[i] = in_trail ? in_data[WIDTH-1-i] : in_data[i];
        end
    end

    for (genvar n = 1; n <= L; n++) begin : lvl
        localparam int NN = WIDTH >> n;
        logic [NN-1:0]          v_d, v_s;
        logic [NN-1:0][n-1:0]   c_d, c_s;

        if (n == 1) begin : g_leaf
            for (genvar k = 0; k < NN; k++) begin : g_k
                assign v_d[k] = |data_ord[2*k +: 2];
                assign c_d[k] = ~data_ord[2*k+1];
            end
        end else begin : g_merge
            for (genvar k = 0; k < NN; k++) begin : g_k
                fpu_lzc_merge #(.N(n-1)) u_merge (
                    .vh_i (lvl[n-1].v_s[2*k+1]),
                    .ch_i (lvl[n-1].c_s[2*k+1]),
                    .vl_i (lvl[n-1].v_s[2*k]),
                    .cl_i (lvl[n-1].c_s[2*k]),
                    .v_o  (v_d[k]),
                    .c_o  (c_d[k])
                );
            end
        end

        if (lzc_is_boundary(n, L, PIPE_EVERY)) begin : g_reg
            logic [NN-1:0]        v_q;
            logic [NN-1:0][n-1:0] c_q;
            always_ff @(posedge clk) begin
                if (adv) begin
                    v_q <= v_d;
                    c_q <= c_d;
                end
            end
            assign v_s = v_q;
            assign c_s = c_q;
        end else begin : g_comb
            assign v_s = v_d;
            assign c_s = c_d;
        end
    end

    logic         root_v;
    logic [L-1:0] root_c;

    assign root_v = lvl[L].v_s[0];
    assign root_c = lvl[L].c_s[0];

    // Node data is not reset; outputs are masked by the valid bit instead.
    assign out_zero  = out_valid & ~root_v;
    assign out_count = ~out_valid ? '0 : (root_v ? {1'b0, root_c} : CW'(WIDTH));
    assign out_tag   = tag_q[S-1];

endmodule

// File: tb/tb_fpu_lzc_pipe.sv
// Scoreboard bench for fpu_lzc_pipe: default instance plus WIDTH=8/P=1 and
// WIDTH=64/P=3 instances checked against a bit-serial reference count.
module tb_fpu_lzc_pipe;

    typedef struct {
        int         cnt;
        bit         zero;
        logic [3:0] tag;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        bit          trail;
        int          cnt;
        bit          zero;
    } vec_t;

    logic clk = 0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic        in_valid, in_ready, in_trail, out_valid, out_ready, out_zero;
    logic [31:0] in_data;
    logic [3:0]  in_tag, out_tag;
    logic [5:0]  out_count;

    // sweep instances share stimulus
    logic        s_valid, s_trail, s_oready;
    logic [63:0] s_data;
    logic [3:0]  s_tag;
    logic        r8_rdy, o8_valid, o8_zero, r64_rdy, o64_valid, o64_zero;
    logic [3:0]  o8_count, o8_tag, o64_tag;
    logic [6:0]  o64_count;

    fpu_lzc_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_trail(in_trail), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    fpu_lzc_pipe #(.WIDTH(8), .PIPE_EVERY(1), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r8_rdy),
        .in_data(s_data[7:0]), .in_trail(s_trail), .in_tag(s_tag),
        .out_valid(o8_valid), .out_ready(s_oready), .out_count(o8_count),
        .out_zero(o8_zero), .out_tag(o8_tag)
    );

    fpu_lzc_pipe #(.WIDTH(64), .PIPE_EVERY(3), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r64_rdy),
        .in_data(s_data), .in_trail(s_trail), .in_tag(s_tag),
        .out_valid(o64_valid), .out_ready(s_oready), .out_count(o64_count),
        .out_zero(o64_zero), .out_tag(o64_tag)
    );

    exp_t sb[$];
    exp_t sb8[$];
    exp_t sb64[$];
    bit   chk_lat = 0;
    int   n_pop = 0;
    int   n_stall = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_cnt(input logic [63:0] d, input bit tr, input int w);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) begin
            if (d[tr ? i : w-1-i]) return n;
            n++;
        end
        return n;
    endfunction

    task automatic send(input logic [31:0] d, input bit tr, input logic [3:0] tg,
                        input int ec, input bit ez);
        int n;
        n = 0;
        in_valid = 1; in_data = d; in_trail = tr; in_tag = tg;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_accept_timeout", 0, 1);
        else sb.push_back('{ec, ez, tg, cyc});
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() + sb8.size() + sb64.size()) != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", sb.size() + sb8.size() + sb64.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // main DUT monitor: scoreboard pop, stall behaviour and output hold
    logic       stall_prev = 0;
    logic [5:0] p_cnt;
    logic [3:0] p_tag;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL main_extra: got output tag %0d want none", out_tag);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    chk("main_cnt", out_count, e.cnt);
                    chk("main_zero", out_zero, e.zero);
                    chk("main_tag", out_tag, e.tag);
                    if (chk_lat) chk("main_lat", cyc - e.cyc, 3);
                end
            end
            if (out_valid && !out_ready) begin
                n_stall++;
                chk("stall_in_ready", in_ready, 0);
            end
            if (stall_prev) begin
                chk("hold_cnt", out_count, p_cnt);
                chk("hold_tag", out_tag, p_tag);
            end
        end
        stall_prev = !rst && out_valid && !out_ready;
        p_cnt = out_count;
        p_tag = out_tag;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && o8_valid) begin
            if (sb8.size() == 0) begin
                total++; bad++;
                $display("FAIL w8_extra: got output tag %0d want none", o8_tag);
            end else begin
                e = sb8.pop_front();
                chk("w8_cnt", o8_count, e.cnt);
                chk("w8_zero", o8_zero, e.zero);
                chk("w8_tag", o8_tag, e.tag);
                chk("w8_lat", cyc - e.cyc, 3);
            end
        end
        if (!rst && o64_valid) begin
            if (sb64.size() == 0) begin
                total++; bad++;
                $display("FAIL w64_extra: got output tag %0d want none", o64_tag);
            end else begin
                e = sb64.pop_front();
                chk("w64_cnt", o64_count, e.cnt);
                chk("w64_zero", o64_zero, e.zero);
                chk("w64_tag", o64_tag, e.tag);
                chk("w64_lat", cyc - e.cyc, 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vec[9];
        int   pops0;
        vec[0] = '{32'h0000_0001, 1'b0, 31, 1'b0};
        vec[1] = '{32'h8000_0000, 1'b0,  0, 1'b0};
        vec[2] = '{32'h0001_F000, 1'b0, 15, 1'b0};
        vec[3] = '{32'h0000_0000, 1'b0, 32, 1'b1};
        vec[4] = '{32'h0000_0000, 1'b1, 32, 1'b1};
        vec[5] = '{32'h0000_0100, 1'b1,  8, 1'b0};
        vec[6] = '{32'h8000_0000, 1'b1, 31, 1'b0};
        vec[7] = '{32'hFFFF_FFFF, 1'b1,  0, 1'b0};
        vec[8] = '{32'h0001_0000, 1'b0, 15, 1'b0};

        rst = 1; in_valid = 0; in_data = '0; in_trail = 0; in_tag = '0; out_ready = 1;
        s_valid = 0; s_data = '0; s_trail = 0; s_tag = '0; s_oready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_tag", out_tag, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // vector table, back-to-back, latency checked
        chk_lat = 1;
        for (int i = 0; i < 9; i++)
            send(vec[i].data, vec[i].trail, 4'(i), vec[i].cnt, vec[i].zero);
        drain();

        // 8-beat stream with out_ready low for cycles 4-6
        chk_lat = 0;
        pops0 = n_pop;
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    logic [31:0] d;
                    d = $urandom >> $urandom_range(0, 31);
                    send(d, 1'b0, 4'(t), ref_cnt({32'b0, d}, 1'b0, 32), d == 0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("stream_pops", n_pop - pops0, 8);
        chk("stall_seen", n_stall > 0, 1);

        // reset with two beats in flight and an input offered during reset
        chk_lat = 1;
        send(32'h0000_0001, 1'b0, 4'hA, 31, 1'b0);
        send(32'h0000_0002, 1'b0, 4'hB, 30, 1'b0);
        rst = 1; in_valid = 1; in_data = 32'h0000_FFFF; in_tag = 4'hC;
        sb.delete();
        @(posedge clk); #1 rst = 0; in_valid = 0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_flight_no_out", out_valid, 0);
        end
        @(posedge clk); #1;
        pops0 = n_pop;
        send(32'h0000_0400, 1'b0, 4'h5, 21, 1'b0);
        drain();
        chk("post_rst_pops", n_pop - pops0, 1);

        // parameter sweep on random data
        for (int i = 0; i < 40; i++) begin
            logic [63:0] d;
            bit          tr;
            d  = {$urandom, $urandom} >> $urandom_range(0, 63);
            tr = bit'($urandom_range(0, 1));
            if (i < 2) begin
                d  = '0;
                tr = (i == 1);
            end
            s_valid = 1; s_data = d; s_trail = tr; s_tag = 4'(i);
            @(negedge clk);
            chk("sweep_ready", r8_rdy & r64_rdy, 1);
            if (i < 2) begin
                sb8.push_back('{8, 1'b1, 4'(i), cyc});
                sb64.push_back('{64, 1'b1, 4'(i), cyc});
            end else begin
                sb8.push_back('{ref_cnt({56'b0, d[7:0]}, tr, 8), d[7:0] == 0, 4'(i), cyc});
                sb64.push_back('{ref_cnt(d, tr, 64), d == 0, 4'(i), cyc});
            end
            @(posedge clk); #1;
        end
        s_valid = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
